if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage plus IF/ID pipeline register for the five-stage MIPS pipeline. Holds the PC, selects the next PC from sequential, jump, jr and branch redirects, and reads the instruction ROM. It registers the decoded instruction fields, together with PC+4, into the exact field set consumed by the Reg/Dec stage. Supports load-use stalls from the hazard unit and bubble insertion on control-flow redirects.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  current PC, to the instruction ROM.
- imem_data  in  32  instruction at imem_addr; combinational, valid in the same cycle.
- stall_IF  in  1  hazard-unit stall; holds PC and IF/ID.
- Jump_ID  in  1  j/jal decoded in ID this cycle.
- J_Addr_ID  in  32  jump target from ID.
- Jr_EX  in  1  jr/jalr resolved in EX.
- Jr_Target_EX  in  32  jr target (Reg[Rs]).
- Branch_EX  in  1  conditional branch resolved taken in EX.
- Branch_Target_EX  in  32  branch target.
- OP_ID  out  6  instr[31:26].
- Rs_ID  out  5  instr[25:21].
- Rt_ID  out  5  instr[20:16].
- Rd_ID  out  5  instr[15:11].
- shamt_ID  out  5  instr[10:6].
- func_ID  out  6  instr[5:0].
- imm16_ID  out  16  instr[15:0].
- J_Target_ID  out  26  instr[25:0].
- PC_Addr_ID  out  32  PC+4 of the instruction held in IF/ID.
- valid_ID  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_cnt, stall_cnt, flush_cnt  out  32 each  performance counters (only with IF_PERF_CNT_EN).

## Operation
- Next-PC priority, highest first:
  - Branch_EX → Branch_Target_EX
  - Jr_EX → Jr_Target_EX
  - Jump_ID && !stall_IF → J_Addr_ID
  - stall_IF → PC held
  - otherwise PC+4
- Branch and jr are older than the ID instruction, so they override both stall and jump.
- Jump_ID is ignored while stall_IF=1. The jump instruction stays in ID and is seen again on the next cycle.
- Redirect targets have bits [1:0] forced to 2'b00. PC+4 is 32-bit modulo: 32'hFFFF_FFFC wraps to 0.
- IF/ID update, in priority order:
  - Flush: any redirect taken (Branch_EX, Jr_EX, or Jump_ID && !stall_IF). All fields are cleared to 0, which is the NOP encoding sll $0,$0,0. valid_ID=0.
  - Hold: stall_IF=1 with no redirect. All IF/ID fields are unchanged.
  - Load: otherwise. Fields are loaded from imem_data, PC_Addr_ID <= PC+4, and valid_ID <= 1.
- Branch_EX/Jr_EX redirects flush only IF/ID. Flushing ID/EX is owned by the hazard unit.
- Reset:
  - PC=RESET_PC.
  - All IF/ID outputs 0, valid_ID=0.
  - Counters 0.
  - imem_addr=RESET_PC.

## Timing
- Fetch latency is 1 cycle. The instruction at PC in cycle n appears on the ID outputs in cycle n+1.
- First valid instruction: the first rising edge with rst=0 loads IF/ID from RESET_PC, and PC becomes RESET_PC+4.
- A jump costs 1 bubble. A branch/jr costs 2 bubbles: the IF/ID flush here plus the ID/EX flush done externally.
- Stall is held for k cycles → PC and IF/ID are frozen for exactly k edges. No instruction is lost or duplicated.
- rst asserted mid-stall or mid-redirect takes precedence over everything on that edge.

## Configuration
- IF_PERF_CNT_EN defined: three 32-bit counters, wrapping modulo 2^32 and cleared by rst.
  - fetch_cnt increments on each Load edge.
  - stall_cnt increments on each Hold edge.
  - flush_cnt increments on each Flush edge.
- IF_PERF_CNT_EN undefined: the counter ports and logic are absent. Fetch behaviour is identical.

## Test plan
- Reset release: ROM[0x3000]=0x8C220004, ROM[0x3004]=0x00000020.
  - First edge: OP_ID=6'h23, Rs_ID=1, Rt_ID=2, imm16_ID=4, PC_Addr_ID=0x3004, valid_ID=1.
  - Next edge: PC_Addr_ID=0x3008.
- Stall: assert stall_IF for 3 cycles at PC=0x3008.
  - IF/ID is unchanged and imem_addr stays 0x3008 for 3 edges.
  - After release, 0x3008 is loaded exactly once.
- Jump: Jump_ID=1, J_Addr_ID=0x3100.
  - Next edge: valid_ID=0, all fields 0, imem_addr=0x3100.
  - Following edge: ROM[0x3100] is in ID with PC_Addr_ID=0x3104.
- Simultaneous events: Branch_EX=1 (target 0x3200), Jr_EX=1 (target 0x3300), Jump_ID=1, stall_IF=1 in the same cycle.
  - PC becomes 0x3200 and IF/ID is flushed.
  - Then Jump_ID=1 with stall_IF=1 alone: PC is held and there is no flush.
- Wrap and alignment: RESET_PC=32'hFFFF_FFFC → PC_Addr_ID=0 and next imem_addr=0. Jr_Target_EX=0x3203 → imem_addr=0x3200.
- With IF_PERF_CNT_EN: 10 loads, 3 stalls, 2 flushes → fetch_cnt=10, stall_cnt=3, flush_cnt=2. rst mid-run → all counters 0 on the next edge.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage with PC, next-PC selection and IF/ID pipeline register.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall_IF,
  input  logic        Jump_ID,
  input  logic [31:0] J_Addr_ID,
  input  logic        Jr_EX,
  input  logic [31:0] Jr_Target_EX,
  input  logic        Branch_EX,
  input  logic [31:0] Branch_Target_EX,
  output logic [5:0]  OP_ID,
  output logic [4:0]  Rs_ID,
  output logic [4:0]  Rt_ID,
  output logic [4:0]  Rd_ID,
  output logic [4:0]  shamt_ID,
  output logic [5:0]  func_ID,
  output logic [15:0] imm16_ID,
  output logic [25:0] J_Target_ID,
  output logic [31:0] PC_Addr_ID,
  output logic        valid_ID
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {ACT_LOAD, ACT_HOLD, ACT_FLUSH} act_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] ir;
  logic [31:0] pc4_id;
  logic        valid_q;
  logic        jump_taken;
  act_t        act;

  assign pc_plus4   = pc + 32'd4;
  assign jump_taken = Jump_ID & ~stall_IF;
  assign imem_addr  = pc;

  // Branch/jr are older than the ID instruction, so they beat both stall and jump.
  always_comb begin
    next_pc = pc_plus4;
    act     = ACT_LOAD;
    if (Branch_EX) begin
      next_pc = Branch_Target_EX & ALIGN_MASK;
      act     = ACT_FLUSH;
    end else if (Jr_EX) begin
      next_pc = Jr_Target_EX & ALIGN_MASK;
      act     = ACT_FLUSH;
    end else if (jump_taken) begin
      next_pc = J_Addr_ID & ALIGN_MASK;
      act     = ACT_FLUSH;
    end else if (stall_IF) begin
      next_pc = pc;
      act     = ACT_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      pc4_id  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc <= next_pc;
      unique case (act)
        ACT_FLUSH: begin
          ir      <= '0;
          pc4_id  <= '0;
          valid_q <= 1'b0;
        end
        ACT_HOLD: ;
        default: begin
          ir      <= imem_data;
          pc4_id  <= pc_plus4;
          valid_q <= 1'b1;
        end
      endcase
    end
  end

  // An all-zero IF/ID word decodes as sll $0,$0,0, so the flush is a NOP.
  assign OP_ID       = ir[31:26];
  assign Rs_ID       = ir[25:21];
  assign Rt_ID       = ir[20:16];
  assign Rd_ID       = ir[15:11];
  assign shamt_ID    = ir[10:6];
  assign func_ID     = ir[5:0];
  assign imm16_ID    = ir[15:0];
  assign J_Target_ID = ir[25:0];
  assign PC_Addr_ID  = pc4_id;
  assign valid_ID    = valid_q;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (act)
        ACT_FLUSH: flush_cnt <= flush_cnt + 32'd1;
        ACT_HOLD:  stall_cnt <= stall_cnt + 32'd1;
        default:   fetch_cnt <= fetch_cnt + 32'd1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit with a behavioural ROM.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_data;
  logic        stall_IF, Jump_ID, Jr_EX, Branch_EX;
  logic [31:0] J_Addr_ID, Jr_Target_EX, Branch_Target_EX;
  logic [5:0]  OP_ID, func_ID;
  logic [4:0]  Rs_ID, Rt_ID, Rd_ID, shamt_ID;
  logic [15:0] imm16_ID;
  logic [25:0] J_Target_ID;
  logic [31:0] PC_Addr_ID;
  logic        valid_ID;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
`endif

  // Second instance at the top of the address space for the wrap case.
  logic [31:0] w_addr, w_data, w_pc4;
  logic [5:0]  w_op, w_func;
  logic [4:0]  w_rs, w_rt, w_rd, w_sh;
  logic [15:0] w_imm;
  logic [25:0] w_jt;
  logic        w_valid;

  int unsigned ncmp = 0;
  int unsigned nfail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_3000: rom = 32'h8C22_0004;
      32'h0000_3004: rom = 32'h0000_0020;
      default:       rom = {a[15:0], a[15:0] ^ 16'h5A5A};
    endcase
  endfunction

  assign imem_data = rom(imem_addr);
  assign w_data    = rom(w_addr);

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall_IF(stall_IF), .Jump_ID(Jump_ID), .J_Addr_ID(J_Addr_ID),
    .Jr_EX(Jr_EX), .Jr_Target_EX(Jr_Target_EX),
    .Branch_EX(Branch_EX), .Branch_Target_EX(Branch_Target_EX),
    .OP_ID(OP_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID),
    .shamt_ID(shamt_ID), .func_ID(func_ID), .imm16_ID(imm16_ID),
    .J_Target_ID(J_Target_ID), .PC_Addr_ID(PC_Addr_ID), .valid_ID(valid_ID)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] w_fc, w_sc, w_flc;
`endif

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem_addr(w_addr), .imem_data(w_data),
    .stall_IF(1'b0), .Jump_ID(1'b0), .J_Addr_ID(32'h0),
    .Jr_EX(1'b0), .Jr_Target_EX(32'h0),
    .Branch_EX(1'b0), .Branch_Target_EX(32'h0),
    .OP_ID(w_op), .Rs_ID(w_rs), .Rt_ID(w_rt), .Rd_ID(w_rd),
    .shamt_ID(w_sh), .func_ID(w_func), .imm16_ID(w_imm),
    .J_Target_ID(w_jt), .PC_Addr_ID(w_pc4), .valid_ID(w_valid)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(w_fc), .stall_cnt(w_sc), .flush_cnt(w_flc)
`endif
  );

  typedef struct {
    logic        stall, jump, jr, br;
    logic [31:0] jaddr, jrt, brt;
    logic [31:0] exp_addr, exp_instr, exp_pc4;
    logic        exp_valid;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mkv(input logic s, input logic j, input logic [31:0] ja,
                               input logic r, input logic [31:0] rt,
                               input logic b, input logic [31:0] bt,
                               input logic [31:0] ea, input logic [31:0] ei,
                               input logic [31:0] ep, input logic ev);
    vec_t v;
    v.stall = s; v.jump = j; v.jaddr = ja; v.jr = r; v.jrt = rt; v.br = b; v.brt = bt;
    v.exp_addr = ea; v.exp_instr = ei; v.exp_pc4 = ep; v.exp_valid = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] id_word();
    return {OP_ID, Rs_ID, Rt_ID, Rd_ID, shamt_ID, func_ID};
  endfunction

  task automatic check_id(input string tag, input logic [31:0] ea, input logic [31:0] ei,
                          input logic [31:0] ep, input logic ev);
    chk({tag, ".imem_addr"}, imem_addr, ea);
    chk({tag, ".instr"}, id_word(), ei);
    chk({tag, ".imm16"}, {16'h0, imm16_ID}, {16'h0, ei[15:0]});
    chk({tag, ".jtarget"}, {6'h0, J_Target_ID}, {6'h0, ei[25:0]});
    chk({tag, ".pc4"}, PC_Addr_ID, ep);
    chk({tag, ".valid"}, {31'h0, valid_ID}, {31'h0, ev});
  endtask

  task automatic drive(input logic s, input logic j, input logic [31:0] ja,
                       input logic r, input logic [31:0] rt,
                       input logic b, input logic [31:0] bt);
    stall_IF = s; Jump_ID = j; J_Addr_ID = ja;
    Jr_EX = r; Jr_Target_EX = rt; Branch_EX = b; Branch_Target_EX = bt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check_id("reset", 32'h3000, 32'h0, 32'h0, 1'b0);
    chk("reset.wrap_addr", w_addr, 32'hFFFF_FFFC);

    vq.push_back(mkv(0,0,0, 0,0, 0,0, 32'h3004, 32'h8C22_0004, 32'h3004, 1));
    vq.push_back(mkv(0,0,0, 0,0, 0,0, 32'h3008, 32'h0000_0020, 32'h3008, 1));
    vq.push_back(mkv(1,0,0, 0,0, 0,0, 32'h3008, 32'h0000_0020, 32'h3008, 1));
    vq.push_back(mkv(1,0,0, 0,0, 0,0, 32'h3008, 32'h0000_0020, 32'h3008, 1));
    vq.push_back(mkv(1,0,0, 0,0, 0,0, 32'h3008, 32'h0000_0020, 32'h3008, 1));
    vq.push_back(mkv(0,0,0, 0,0, 0,0, 32'h300C, rom(32'h3008), 32'h300C, 1));
    vq.push_back(mkv(0,1,32'h3100, 0,0, 0,0, 32'h3100, 32'h0, 32'h0, 0));
    vq.push_back(mkv(0,0,0, 0,0, 0,0, 32'h3104, rom(32'h3100), 32'h3104, 1));
    vq.push_back(mkv(1,1,32'h3400, 1,32'h3300, 1,32'h3200, 32'h3200, 32'h0, 32'h0, 0));
    vq.push_back(mkv(0,0,0, 0,0, 0,0, 32'h3204, rom(32'h3200), 32'h3204, 1));
    vq.push_back(mkv(1,1,32'h3400, 0,0, 0,0, 32'h3204, rom(32'h3200), 32'h3204, 1));
    vq.push_back(mkv(0,1,32'h3502, 0,0, 0,0, 32'h3500, 32'h0, 32'h0, 0));
    vq.push_back(mkv(0,0,0, 1,32'h3203, 0,0, 32'h3200, 32'h0, 32'h0, 0));
    vq.push_back(mkv(1,0,0, 0,0, 1,32'h3011, 32'h3010, 32'h0, 32'h0, 0));
    vq.push_back(mkv(0,0,0, 0,0, 0,0, 32'h3014, rom(32'h3010), 32'h3014, 1));

    rst = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].stall, vq[i].jump, vq[i].jaddr, vq[i].jr, vq[i].jrt, vq[i].br, vq[i].brt);
      step();
      check_id($sformatf("vec%0d", i), vq[i].exp_addr, vq[i].exp_instr,
               vq[i].exp_pc4, vq[i].exp_valid);
    end

    // Reset on an edge that also carries a stall and a redirect.
    drive(1, 1, 32'h3400, 1, 32'h3300, 1, 32'h3200);
    rst = 1'b1;
    step();
    check_id("rst_mid", 32'h3000, 32'h0, 32'h0, 1'b0);
    chk("wrap.reset_addr", w_addr, 32'hFFFF_FFFC);

    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    chk("wrap.pc4", w_pc4, 32'h0);
    chk("wrap.addr", w_addr, 32'h0);
    chk("wrap.valid", {31'h0, w_valid}, 32'h1);
    chk("wrap.instr", {w_op, w_rs, w_rt, w_rd, w_sh, w_func}, rom(32'hFFFF_FFFC));
    chk("first.op", {26'h0, OP_ID}, 32'h23);
    chk("first.rs", {27'h0, Rs_ID}, 32'h1);
    chk("first.rt", {27'h0, Rt_ID}, 32'h2);

`ifdef IF_PERF_CNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin drive(0, 0, 0, 0, 0, 0, 0); step(); end
    for (int i = 0; i < 3; i++)  begin drive(1, 0, 0, 0, 0, 0, 0); step(); end
    for (int i = 0; i < 2; i++)  begin drive(0, 1, 32'h3000, 0, 0, 0, 0); step(); end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("cnt.fetch", fetch_cnt, 32'd10);
    chk("cnt.stall", stall_cnt, 32'd3);
    chk("cnt.flush", flush_cnt, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("cnt.fetch_rst", fetch_cnt, 32'd0);
    chk("cnt.stall_rst", stall_cnt, 32'd0);
    chk("cnt.flush_rst", flush_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
